pipelined_barrel_shifter: RTL

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/pipelined_barrel_shifter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Logarithmic barrel shifter with one register stage per
//               shift-amount bit and valid/ready handshakes on both sides.
//               Stage i conditionally shifts by 2^(STAGES-1-i), so the MSB of
//               the shift amount is consumed first.
//
//               Ops: 00 SLL, 01 SRL, 10 SRA, 11 ROR (or SRL, see below).
//
//               Optional feature macro: BARREL_ROTATE_EN
//                 defined   -> op 11 rotates right (LSB bits wrap to MSB)
//                 undefined -> op 11 behaves as SRL, no wrap logic built
//
// Ports       : clk        single clock, rising edge
//               reset      synchronous active-high reset
//               in_valid   operand valid
//               in_ready   operand accepted this cycle (== global advance)
//               in_data    operand, WIDTH bits
//               in_shamt   shift amount, STAGES bits
//               in_op      operation select, 2 bits
//               out_valid  result valid
//               out_ready  downstream accepts result
//               out_data   shifted result, WIDTH bits
//               out_zero   out_data is all zeros (qualified by out_valid)
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int  WIDTH  = 16,             // power of two, 4..64
    localparam int STAGES = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STAGES-1:0] in_shamt,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_zero
);

    // ------------------------------------------------------------------
    // Stage registers: element k holds the operand after stage k.
    // The whole shift amount travels with the operand; each later stage
    // only looks at its own (lower) bit of it.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data  [STAGES];
    logic [STAGES-1:0] r_shamt [STAGES];
    logic [1:0]        r_op    [STAGES];
    logic              r_zero;

    logic [WIDTH-1:0]  w_next_data [STAGES];
    logic              w_advance;

    // The whole pipe moves as one: a bubble still occupies a slot, and the
    // pipe only freezes when a valid result sits unclaimed at the output.
    assign w_advance = out_ready || !r_valid[STAGES-1];
    assign in_ready  = w_advance;

    // ------------------------------------------------------------------
    // Per-stage combinational shift
    // ------------------------------------------------------------------
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int c_bit = STAGES - 1 - i;
        localparam int c_amt = 1 << c_bit;

        logic [WIDTH-1:0]  w_src_data;
        logic [STAGES-1:0] w_src_shamt;
        logic [1:0]        w_src_op;
        logic [WIDTH-1:0]  w_shifted;

        if (i == 0) begin : g_head
            assign w_src_data  = in_data;
            assign w_src_shamt = in_shamt;
            assign w_src_op    = in_op;
        end else begin : g_body
            assign w_src_data  = r_data[i-1];
            assign w_src_shamt = r_shamt[i-1];
            assign w_src_op    = r_op[i-1];
        end

        // SRA relies on the operand MSB surviving every earlier stage,
        // which it does because each arithmetic step replicates it.
        always_comb begin
            w_shifted = w_src_data >> c_amt;
            case (w_src_op)
                2'b00:   w_shifted = w_src_data << c_amt;
                2'b10:   w_shifted = $signed(w_src_data) >>> c_amt;
`ifdef BARREL_ROTATE_EN
                2'b11:   w_shifted = (w_src_data >> c_amt)
                                   | (w_src_data << (WIDTH - c_amt));
`endif
                default: w_shifted = w_src_data >> c_amt;
            endcase
        end

        assign w_next_data[i] = w_src_shamt[c_bit] ? w_shifted : w_src_data;
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_zero  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
                r_op[k]    <= '0;
            end
        end else if (w_advance) begin
            // Payload is captured unconditionally; with in_valid low the
            // slot is marked empty so its contents are never observed.
            r_valid    <= {r_valid[STAGES-2:0], in_valid};
            r_shamt[0] <= in_shamt;
            r_op[0]    <= in_op;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= w_next_data[k];
            end
            for (int k = 1; k < STAGES; k++) begin
                r_shamt[k] <= r_shamt[k-1];
                r_op[k]    <= r_op[k-1];
            end
            // Zero flag is produced alongside the final data so both
            // change on the same edge.
            r_zero <= (w_next_data[STAGES-1] == '0);
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_zero  = r_zero;

    // Last-stage control fields have no consumer beyond the output.
    logic w_unused_tail;
    assign w_unused_tail = ^{r_shamt[STAGES-1], r_op[STAGES-1]};

endmodule
`default_nettype wire
